// File: rtl/spi_tx_arbiter_if.sv
// Bundles the producer-side byte streams and the SPI transmit handshake
// shared by the transmit arbiter and whatever drives it.
interface spi_tx_arbiter_if;
    logic [2:0]  req_in;
    logic [23:0] byte_in;
    logic [2:0]  byte_valid_in;
    logic [2:0]  byte_last_in;
    logic [2:0]  byte_ack_out;
    logic [2:0]  grant_out;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        timeout_flag;
    logic [1:0]  timeout_src;

    modport master (
        output req_in, byte_in, byte_valid_in, byte_last_in, tx_ready,
        input  byte_ack_out, grant_out, tx_byte, tx_valid, busy,
               timeout_flag, timeout_src
    );

    modport slave (
        input  req_in, byte_in, byte_valid_in, byte_last_in, tx_ready,
        output byte_ack_out, grant_out, tx_byte, tx_valid, busy,
               timeout_flag, timeout_src
    );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin owner of the single SPI transmit byte path shared by the
// mem table, error table and status producers; one packet per grant.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no owner; arbitrate among req_in
// S_HDR   | present source-ID header byte 0xA0|src
// S_STREAM| pass granted producer's bytes through until its last byte
// S_TERM  | producer starved too long; send 0xEE terminator to close
module spi_tx_arbiter #(
    parameter bit          HDR_EN      = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic             sysClk,
    input logic             sysRst_n,
    spi_tx_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_STREAM,
        S_TERM
    } state_t;

    localparam logic [15:0] TC_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state, state_nxt;
    logic [1:0]  src, src_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        tflag, tflag_nxt;
    logic [1:0]  tsrc, tsrc_nxt;

    logic [3:0]  req_pad, valid_pad, last_pad;
    logic [1:0]  cand_1, cand_2, winner;
    logic        any_req;
    logic [7:0]  sel_byte;
    logic        sel_valid, sel_last;
    logic [2:0]  src_onehot;

    logic [7:0]  tx_byte_c;
    logic        tx_valid_c;
    logic [2:0]  ack_c;

    function automatic logic [1:0] rr_next(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Padding to 4 bits keeps the 2-bit source index in range everywhere.
    assign req_pad    = {1'b0, bus.req_in};
    assign valid_pad  = {1'b0, bus.byte_valid_in};
    assign last_pad   = {1'b0, bus.byte_last_in};
    assign any_req    = |bus.req_in;
    assign sel_valid  = valid_pad[src];
    assign sel_last   = last_pad[src];
    assign src_onehot = 3'(3'b001 << src);

    always_comb begin
        cand_1 = rr_next(ptr);
        cand_2 = rr_next(cand_1);
        if (req_pad[cand_1])
            winner = cand_1;
        else if (req_pad[cand_2])
            winner = cand_2;
        else
            winner = ptr;
    end

    always_comb begin
        case (src)
            2'd0:    sel_byte = bus.byte_in[7:0];
            2'd1:    sel_byte = bus.byte_in[15:8];
            default: sel_byte = bus.byte_in[23:16];
        endcase
    end

    always_comb begin
        state_nxt  = state;
        src_nxt    = src;
        ptr_nxt    = ptr;
        cnt_nxt    = cnt;
        tflag_nxt  = 1'b0;
        tsrc_nxt   = tsrc;
        tx_byte_c  = 8'h00;
        tx_valid_c = 1'b0;
        ack_c      = 3'b000;

        case (state)
            S_IDLE: begin
                cnt_nxt = 16'd0;
                if (any_req) begin
                    src_nxt   = winner;
                    ptr_nxt   = winner;
                    state_nxt = HDR_EN ? S_HDR : S_STREAM;
                end
            end
            S_HDR: begin
                tx_byte_c  = {4'hA, 2'b00, src};
                tx_valid_c = 1'b1;
                cnt_nxt    = 16'd0;
                if (bus.tx_ready)
                    state_nxt = S_STREAM;
            end
            S_STREAM: begin
                tx_byte_c  = sel_byte;
                tx_valid_c = sel_valid;
                if (sel_valid && bus.tx_ready) begin
                    ack_c   = src_onehot;
                    cnt_nxt = 16'd0;
                    if (sel_last)
                        state_nxt = S_IDLE;
                end else if (!sel_valid) begin
                    // Only producer starvation counts; tx_ready backpressure does not.
                    cnt_nxt = cnt + 16'd1;
                    if (cnt == TC_LAST) begin
                        state_nxt = S_TERM;
                        tflag_nxt = 1'b1;
                        tsrc_nxt  = src;
                    end
                end
            end
            S_TERM: begin
                tx_byte_c  = 8'hEE;
                tx_valid_c = 1'b1;
                if (bus.tx_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            state <= S_IDLE;
            src   <= 2'd0;
            ptr   <= 2'd2;
            cnt   <= 16'd0;
            tflag <= 1'b0;
            tsrc  <= 2'd0;
        end else begin
            state <= state_nxt;
            src   <= src_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            tflag <= tflag_nxt;
            tsrc  <= tsrc_nxt;
        end
    end

    assign bus.tx_byte      = tx_byte_c;
    assign bus.tx_valid     = tx_valid_c;
    assign bus.byte_ack_out = ack_c;
    assign bus.grant_out    = (state == S_IDLE) ? 3'b000 : src_onehot;
    assign bus.busy         = (state != S_IDLE);
    assign bus.timeout_flag = tflag;
    assign bus.timeout_src  = tsrc;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: a vector table for a plain packet plus
// hand-written contention, backpressure, timeout, reset and no-header runs.
module tb_spi_tx_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_tx_arbiter_if ifa ();
    spi_tx_arbiter_if ifb ();

    spi_tx_arbiter #(.HDR_EN(1'b1), .TIMEOUT_CYC(16)) dut_a (
        .sysClk  (clk),
        .sysRst_n(rst_n),
        .bus     (ifa.slave)
    );

    spi_tx_arbiter #(.HDR_EN(1'b0), .TIMEOUT_CYC(16)) dut_b (
        .sysClk  (clk),
        .sysRst_n(rst_n),
        .bus     (ifb.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] bytes;
        logic [2:0]  vld;
        logic [2:0]  lst;
        logic        rdy;
        logic [2:0]  e_grant;
        logic [7:0]  e_byte;
        logic        e_valid;
        logic [2:0]  e_ack;
        logic        e_busy;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ifa.req_in = 3'b000; ifa.byte_in = 24'h0; ifa.byte_valid_in = 3'b000;
        ifa.byte_last_in = 3'b000; ifa.tx_ready = 1'b1;
        ifb.req_in = 3'b000; ifb.byte_in = 24'h0; ifb.byte_valid_in = 3'b000;
        ifb.byte_last_in = 3'b000; ifb.tx_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [8:0] obs_a();
        return ifa.tx_valid ? {1'b0, ifa.tx_byte} : 9'h100;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          idx [3];
        logic [8:0]  exp_tr [16];
        logic [7:0]  q [$];
        logic [8:0]  e;
        logic [8:0]  got;
        int          bidx;
        bit          done;
        bit          hdr_done;

        // ------------------------------------------------ reset state
        clear_inputs();
        do_reset();
        #1;
        chk("rst grant", ifa.grant_out, 3'b000);
        chk("rst tx_valid", ifa.tx_valid, 1'b0);
        chk("rst tx_byte", ifa.tx_byte, 8'h00);
        chk("rst busy", ifa.busy, 1'b0);
        chk("rst ack", ifa.byte_ack_out, 3'b000);
        chk("rst flag", ifa.timeout_flag, 1'b0);
        chk("rst tsrc", ifa.timeout_src, 2'd0);

        // ------------------------------------------------ no-header instance
        @(negedge clk);
        ifb.req_in = 3'b001; ifb.byte_in = 24'h00005A;
        ifb.byte_valid_in = 3'b001; ifb.byte_last_in = 3'b001;
        #1;
        chk("nohdr c0 grant", ifb.grant_out, 3'b000);
        chk("nohdr c0 valid", ifb.tx_valid, 1'b0);
        @(negedge clk);
        ifb.req_in = 3'b000;
        #1;
        chk("nohdr c1 grant", ifb.grant_out, 3'b001);
        chk("nohdr c1 byte", ifb.tx_byte, 8'h5A);
        chk("nohdr c1 valid", ifb.tx_valid, 1'b1);
        chk("nohdr c1 ack", ifb.byte_ack_out, 3'b001);
        @(negedge clk);
        ifb.byte_valid_in = 3'b000; ifb.byte_last_in = 3'b000;
        #1;
        chk("nohdr c2 busy", ifb.busy, 1'b0);
        chk("nohdr c2 valid", ifb.tx_valid, 1'b0);

        // ------------------------------------------------ single request table
        vt[0] = '{3'b010, 24'h000000, 3'b000, 3'b000, 1'b1, 3'b000, 8'h00, 1'b0, 3'b000, 1'b0};
        vt[1] = '{3'b000, 24'h001177, 3'b011, 3'b000, 1'b1, 3'b010, 8'hA1, 1'b1, 3'b000, 1'b1};
        vt[2] = '{3'b001, 24'h001177, 3'b011, 3'b000, 1'b1, 3'b010, 8'h11, 1'b1, 3'b010, 1'b1};
        vt[3] = '{3'b001, 24'h002277, 3'b011, 3'b000, 1'b0, 3'b010, 8'h22, 1'b1, 3'b000, 1'b1};
        vt[4] = '{3'b001, 24'h002277, 3'b011, 3'b000, 1'b1, 3'b010, 8'h22, 1'b1, 3'b010, 1'b1};
        vt[5] = '{3'b000, 24'h003377, 3'b011, 3'b010, 1'b1, 3'b010, 8'h33, 1'b1, 3'b010, 1'b1};
        vt[6] = '{3'b000, 24'h000000, 3'b000, 3'b000, 1'b1, 3'b000, 8'h00, 1'b0, 3'b000, 1'b0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ifa.req_in = vt[i].req; ifa.byte_in = vt[i].bytes;
            ifa.byte_valid_in = vt[i].vld; ifa.byte_last_in = vt[i].lst;
            ifa.tx_ready = vt[i].rdy;
            #1;
            chk($sformatf("vec%0d grant", i), ifa.grant_out, vt[i].e_grant);
            chk($sformatf("vec%0d tx_byte", i), ifa.tx_byte, vt[i].e_byte);
            chk($sformatf("vec%0d tx_valid", i), ifa.tx_valid, vt[i].e_valid);
            chk($sformatf("vec%0d ack", i), ifa.byte_ack_out, vt[i].e_ack);
            chk($sformatf("vec%0d busy", i), ifa.busy, vt[i].e_busy);
        end

        // ------------------------------------------------ contention
        exp_tr = '{9'h100, 9'h0A0, 9'h010, 9'h011,
                   9'h100, 9'h0A1, 9'h020, 9'h021,
                   9'h100, 9'h0A2, 9'h030, 9'h031,
                   9'h100, 9'h0A0, 9'h010, 9'h011};
        do_reset();
        for (int s = 0; s < 3; s++) idx[s] = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ifa.req_in = 3'b111; ifa.byte_valid_in = 3'b111; ifa.tx_ready = 1'b1;
            for (int s = 0; s < 3; s++) begin
                ifa.byte_in[8*s +: 8] = 8'((s + 1) * 16 + idx[s]);
                ifa.byte_last_in[s]   = (idx[s] == 1);
            end
            #1;
            chk($sformatf("rr cyc%0d", c), obs_a(), exp_tr[c]);
            for (int s = 0; s < 3; s++)
                if (ifa.byte_ack_out[s]) idx[s] = idx[s] ^ 1;
        end

        // ------------------------------------------------ backpressure
        do_reset();
        q.delete();
        bidx = 0; done = 1'b0; hdr_done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            ifa.req_in = (c == 0) ? 3'b001 : 3'b000;
            ifa.byte_in = {16'h0, 8'(bidx + 1)};
            ifa.byte_valid_in = 3'b001;
            ifa.byte_last_in = {2'b00, (bidx == 7)};
            ifa.tx_ready = (c % 2 == 0);
            #1;
            chk($sformatf("bp ack gate cyc%0d", c), ifa.byte_ack_out & {3{~ifa.tx_ready}}, 3'b000);
            if (ifa.tx_valid && !hdr_done)
                chk($sformatf("bp hdr hold cyc%0d", c), ifa.tx_byte, 8'hA0);
            if (ifa.tx_valid && ifa.tx_ready) begin
                q.push_back(ifa.tx_byte);
                hdr_done = 1'b1;
            end
            if (ifa.byte_ack_out[0]) begin
                if (bidx == 7) done = 1'b1;
                bidx++;
            end
        end
        chk("bp completed", done, 1'b1);
        chk("bp count", q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            got = (i < q.size()) ? {1'b0, q[i]} : 9'h1FF;
            e   = (i == 0) ? 9'h0A0 : 9'(i);
            chk($sformatf("bp byte%0d", i), got, e);
        end
        @(negedge clk);
        ifa.byte_valid_in = 3'b000; ifa.byte_last_in = 3'b000;
        #1;
        chk("bp idle busy", ifa.busy, 1'b0);

        // ------------------------------------------------ timeout
        do_reset();
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            ifa.req_in = (c == 0) ? 3'b100 : 3'b001;
            ifa.byte_in = 24'h420000;
            ifa.byte_valid_in = (c == 1 || c == 2) ? 3'b100 : 3'b000;
            ifa.byte_last_in = 3'b000;
            ifa.tx_ready = 1'b1;
            #1;
            e = 9'h100;
            if (c == 1)  e = 9'h0A2;
            if (c == 2)  e = 9'h042;
            if (c == 19) e = 9'h0EE;
            if (c == 21) e = 9'h0A0;
            chk($sformatf("to tx cyc%0d", c), obs_a(), e);
            chk($sformatf("to flag cyc%0d", c), ifa.timeout_flag, (c == 19));
            if (c == 19) chk("to src", ifa.timeout_src, 2'd2);
            if (c == 20) chk("to idle", ifa.busy, 1'b0);
            if (c == 21) begin
                chk("to next grant", ifa.grant_out, 3'b001);
                chk("to src held", ifa.timeout_src, 2'd2);
            end
        end

        // ------------------------------------------------ reset mid-packet
        do_reset();
        @(negedge clk);
        ifa.req_in = 3'b010;
        @(negedge clk);
        ifa.req_in = 3'b000;
        ifa.byte_in = 24'h001100; ifa.byte_valid_in = 3'b010; ifa.tx_ready = 1'b1;
        @(negedge clk);
        ifa.tx_ready = 1'b0;
        #1;
        chk("mid busy before rst", ifa.busy, 1'b1);
        chk("mid grant before rst", ifa.grant_out, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst grant", ifa.grant_out, 3'b000);
        chk("mid rst tx_valid", ifa.tx_valid, 1'b0);
        chk("mid rst tx_byte", ifa.tx_byte, 8'h00);
        chk("mid rst busy", ifa.busy, 1'b0);
        chk("mid rst ack", ifa.byte_ack_out, 3'b000);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        ifa.req_in = 3'b110;
        @(negedge clk);
        #1;
        chk("post rst grant src1", ifa.grant_out, 3'b010);
        do_reset();
        ifa.req_in = 3'b111;
        @(negedge clk);
        #1;
        chk("post rst grant src0", ifa.grant_out, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
